// File: rtl/morse_pkg.sv
// Shared types and datapath limits for the Morse key front end.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_WAIT_WORD
  } seq_state_t;

  // Limits imposed by the encoder's 10-bit symbol field and the 160-bit store.
  localparam int unsigned MAX_SYMS  = 5;
  localparam int unsigned MAX_CHARS = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/morse_key_sequencer_if.sv
// Key/button inputs and strobe/status outputs of the Morse key sequencer.
interface morse_key_sequencer_if;
  logic Key;
  logic EnterBtn;
  logic Dot;
  logic Dash;
  logic EndSeq;
  logic Space;
  logic Enter;
  logic Full;
  logic SymErr;

  modport master (
    output Key, EnterBtn,
    input  Dot, Dash, EndSeq, Space, Enter, Full, SymErr
  );

  modport slave (
    input  Key, EnterBtn,
    output Dot, Dash, EndSeq, Space, Enter, Full, SymErr
  );
endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a stability counter.
module key_debouncer #(
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Stable means both sync stages agree, so a single-cycle pulse never qualifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if ((s1 != s2) || (s2 == db)) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/morse_key_sequencer.sv
// Straight-key front end: times marks and gaps, emits Dot/Dash/EndSeq/Space/Enter strobes.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned DEBOUNCE = 8,
  parameter int unsigned DOT_MAX  = 2,
  parameter int unsigned CHAR_GAP = 3,
  parameter int unsigned WORD_GAP = 7
) (
  input logic                   Clk,
  input logic                   Reset,
  morse_key_sequencer_if.slave  bus
);

  localparam int unsigned  PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0]   DOT_LIM  = 8'(DOT_MAX);
  localparam logic [7:0]   CG_LIM   = 8'(CHAR_GAP);
  localparam logic [7:0]   WG_LIM   = 8'(WORD_GAP);
  localparam logic [2:0]   SYM_LIM  = 3'(MAX_SYMS);
  localparam logic [4:0]   CHAR_LIM = 5'(MAX_CHARS);

  seq_state_t    state, state_n;
  logic [PW-1:0] pc, pc_n;
  logic          tick;
  logic [7:0]    dur, dur_n;
  logic [2:0]    symcnt, symcnt_n;
  logic [4:0]    charcnt, charcnt_n;
  logic          sym_err, sym_err_n;
  logic          enter_pend, enter_pend_n;
  logic          key_db, ent_db, key_q, ent_q;
  logic          key_rise, ent_rise, full, busy;
  logic          dot_n, dash_n, end_n, space_n, enter_n;
  logic          dot_q, dash_q, end_q, space_q, enter_q;

  key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_key_db (
    .clk(Clk), .rst(Reset), .raw(bus.Key), .db(key_db)
  );

  key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_ent_db (
    .clk(Clk), .rst(Reset), .raw(bus.EnterBtn), .db(ent_db)
  );

  assign key_rise = key_db & ~key_q;
  assign ent_rise = ent_db & ~ent_q;
  assign full     = (charcnt == CHAR_LIM);
  assign tick     = (pc == PW'(TICK_DIV - 1));
  // A strobe still on the outputs defers the next strobe-producing action by a cycle.
  assign busy     = dot_q | dash_q | end_q | space_q | enter_q;

  always_comb begin
    state_n      = state;
    symcnt_n     = symcnt;
    charcnt_n    = charcnt;
    sym_err_n    = sym_err;
    enter_pend_n = enter_pend;
    dur_n        = dur;
    pc_n         = pc;
    dot_n        = 1'b0;
    dash_n       = 1'b0;
    end_n        = 1'b0;
    space_n      = 1'b0;
    enter_n      = 1'b0;

    case (state)
      ST_IDLE, ST_WAIT_WORD: begin
        if (enter_pend) begin
          if (!busy) begin
            enter_n      = 1'b1;
            charcnt_n    = '0;
            symcnt_n     = '0;
            sym_err_n    = 1'b0;
            enter_pend_n = 1'b0;
            state_n      = ST_IDLE;
          end
        end else if (key_rise && !full) begin
          state_n = ST_MARK;
        end else if ((state == ST_WAIT_WORD) && !busy && (dur >= WG_LIM)) begin
          state_n = ST_IDLE;
          if (!full) begin
            space_n   = 1'b1;
            charcnt_n = charcnt + 5'd1;
          end
        end
      end
      ST_MARK: begin
        if (!key_db) begin
          state_n = ST_GAP;
          if (symcnt < SYM_LIM) begin
            dot_n    = (dur <= DOT_LIM);
            dash_n   = (dur > DOT_LIM);
            symcnt_n = symcnt + 3'd1;
          end else begin
            sym_err_n = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (key_db) begin
          state_n = ST_MARK;
        end else if (!busy && ((dur >= CG_LIM) || enter_pend)) begin
          end_n     = 1'b1;
          charcnt_n = full ? charcnt : charcnt + 5'd1;
          symcnt_n  = '0;
          state_n   = ST_WAIT_WORD;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (ent_rise) enter_pend_n = 1'b1;

    if ((state_n != state) || tick) pc_n = '0;
    else                            pc_n = pc + PW'(1);

    if ((state_n != state) && ((state_n == ST_MARK) || (state_n == ST_GAP))) dur_n = '0;
    else if (tick)                                                          dur_n = sat_inc8(dur);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      pc         <= '0;
      dur        <= '0;
      symcnt     <= '0;
      charcnt    <= '0;
      sym_err    <= 1'b0;
      enter_pend <= 1'b0;
      key_q      <= 1'b0;
      ent_q      <= 1'b0;
      dot_q      <= 1'b0;
      dash_q     <= 1'b0;
      end_q      <= 1'b0;
      space_q    <= 1'b0;
      enter_q    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      dur        <= dur_n;
      symcnt     <= symcnt_n;
      charcnt    <= charcnt_n;
      sym_err    <= sym_err_n;
      enter_pend <= enter_pend_n;
      key_q      <= key_db;
      ent_q      <= ent_db;
      dot_q      <= dot_n;
      dash_q     <= dash_n;
      end_q      <= end_n;
      space_q    <= space_n;
      enter_q    <= enter_n;
    end
  end

  assign bus.Dot    = dot_q;
  assign bus.Dash   = dash_q;
  assign bus.EndSeq = end_q;
  assign bus.Space  = space_q;
  assign bus.Enter  = enter_q;
  assign bus.Full   = full;
  assign bus.SymErr = sym_err;

endmodule

// File: doc/morse_key_sequencer.md
# morse_key_sequencer

Front-end controller for the Morse translator chain. It turns a single raw straight-key level and a raw Enter button into the one-cycle Dot, Dash, EndSeq, Space and Enter strobes consumed by `morse_code_encoder` and `sequence_storage`. It measures key-down and key-up durations, sequences character and word boundaries, and enforces the datapath limits of 5 symbols per character and 16 stored sequences.

## Interface
- `TICK_DIV`, 1000: clock cycles per timing tick.
- `DEBOUNCE`, 8: cycles a synchronized input must stay stable before it is accepted.
- `DOT_MAX`, 2: a mark of at most this many ticks is a Dot; a longer mark is a Dash.
- `CHAR_GAP`, 3: ticks of key-up that close a character. Must be ≥1 and < `WORD_GAP`.
- `WORD_GAP`, 7: ticks of key-up, counted from key release, that insert a Space. Must be ≤255.
- `Clk` in 1: single clock.
- `Reset` in 1: synchronous, active-high; clears all state.
- `Key` in 1: raw key level, 1 = pressed, asynchronous.
- `EnterBtn` in 1: raw Enter button, asynchronous.
- `Dot`, `Dash`, `EndSeq`, `Space`, `Enter` out 1 each: registered one-cycle strobes.
- `Full` out 1: 16 sequences are stored; further keying is ignored.
- `SymErr` out 1: sticky; a 6th symbol was dropped in the current message.

## Operation
- Input conditioning:
  - `Key` and `EnterBtn` each pass through a 2-flop synchronizer and then a debouncer, producing KeyDb and EntDb.
  - Only a rising edge of EntDb sets EnterPend.
- Tick prescaler:
  - Free-running counter producing a 1-cycle tick every `TICK_DIV` cycles.
  - The counter restarts on every state transition.
  - Duration counter `dur` is 8 bits, increments on tick, saturates at 255.
- States: IDLE, MARK, GAP, WAIT_WORD.
  - **IDLE**
    - EnterPend → pulse Enter, clear charcnt, symcnt, SymErr and EnterPend, stay in IDLE.
    - Else KeyDb rise with Full=0 → MARK, dur=0.
    - KeyDb rise with Full=1 is ignored.
  - **MARK**
    - KeyDb fall → GAP, dur=0.
    - If symcnt<5: pulse Dot if dur≤`DOT_MAX`, else Dash; symcnt++.
    - If symcnt=5: emit no strobe and set SymErr.
  - **GAP**
    - KeyDb rise → MARK.
    - dur reaches `CHAR_GAP`, or EnterPend is set → pulse EndSeq, charcnt++, symcnt=0, go to WAIT_WORD. `dur` keeps counting.
  - **WAIT_WORD**
    - EnterPend → behave exactly as the IDLE Enter action.
    - Else KeyDb rise with Full=0 → MARK, dur=0. With Full=1 the rise is ignored.
    - Else dur reaches `WORD_GAP` → go to IDLE; if charcnt<16, pulse Space and charcnt++.
- A character whose symbols were all dropped still produces its EndSeq.
- charcnt is 5 bits, saturating at 16. Full = (charcnt==16).
- When Full rises, the EndSeq that caused it is still emitted.
- EnterPend received during MARK is held until GAP is reached.

## Timing
- Reset values:
  - All strobes 0, Full 0, SymErr 0.
  - State IDLE; counters and EnterPend 0.
- Latency:
  - Input to KeyDb/EntDb: 2 + `DEBOUNCE` cycles.
  - Dot/Dash: exactly 1 cycle after the KeyDb fall.
  - EndSeq: 1 cycle after the threshold is reached or EnterPend is seen in GAP.
  - Enter: 1 cycle after EnterPend is seen in IDLE/WAIT_WORD.
- EnterPend during GAP produces EndSeq, then Enter on the following state visit. These are never in the same cycle: at least 1 idle cycle separates them.
- At most one strobe is asserted in any cycle. Each strobe is followed by at least 1 low cycle.
- Reset asserted mid-mark or mid-gap: no strobe is emitted in the cycle after Reset, and any partial character is discarded.

## Structure
- Package `morse_pkg` holds:
  - The state enum.
  - `MAX_SYMS`=5 and `MAX_CHARS`=16, matching the producer's 10-bit width and the storage's 160 bits.
- Sub-module `key_debouncer` (synchronizer plus stable counter), instantiated twice.

## Test plan
Bench parameters: `TICK_DIV`=1, `DEBOUNCE`=1, defaults otherwise. All scenarios are also checked against the downstream translator.
- Key 1 tick, release 3 ticks, key 4 ticks, release 8 ticks → Dot, EndSeq, Dash, EndSeq, Space; translator sees "E T ".
- Six Dots within one character → 5 Dot strobes, then SymErr=1, then one EndSeq.
- 16 single-Dot characters → Full=1 after the 16th EndSeq. A 17th key press produces no strobe, and no Space is generated.
- Enter pressed while key is held, then key released → Dash, EndSeq, Enter in order, each ≥1 cycle apart. Afterwards Full=0 and SymErr=0.
- Reset asserted mid-MARK → no Dot/Dash. Next character's count starts from 0.
- Key bounce of 1-cycle glitches → no strobes.
